perceptron_weight_table: RTL and testbench

Parametrised perceptron weight store for the branch predictor. It serves `NUM_WAYS` parallel weight-vector lookups per cycle and owns the complete training sequence: threshold check, read-modify-write, and per-weight saturating update. Training is a clocked three-state sequence driven by a valid/ready handshake from the branch-resolution stage. Its outputs feed the perceptron dot-product adders in the fetch pipeline.

---
 rtl/perceptron_pkg.sv | 31 +++
 rtl/weight_sat_update.sv | 25 ++
 rtl/perceptron_weight_table.sv | 123 ++++++++++++
 tb/tb_perceptron_weight_table.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron weight table: training FSM states,
// weight saturation limits and the training-needed decision.
package perceptron_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRAIN_RD = 2'd1,
    TRAIN_WR = 2'd2
  } train_state_e;

  function automatic int weight_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int weight_min(input int w);
    return -(1 << (w - 1));
  endfunction

  // The sum arrives sign-extended to 32 bits, so negating the most-negative
  // SUM_W value cannot overflow. sign(0) counts as taken.
  function automatic logic train_needed(input logic signed [31:0] sum,
                                        input logic               taken,
                                        input int                 theta);
    logic signed [31:0] mag;
    logic               sum_taken;
    sum_taken = (sum >= 0);
    mag       = sum_taken ? sum : -sum;
    return (sum_taken != taken) || (mag <= theta);
  endfunction

endpackage

// File: rtl/weight_sat_update.sv
// One signed weight stepped by +1 or -1, clamped at the representable limits
// instead of wrapping.
module weight_sat_update
  import perceptron_pkg::*;
#(
  parameter int WEIGHT_W = 8
) (
  input  logic signed [WEIGHT_W-1:0] weight,
  input  logic                       step_up,
  output logic signed [WEIGHT_W-1:0] result
);

  localparam logic signed [WEIGHT_W-1:0] W_MAX = WEIGHT_W'(weight_max(WEIGHT_W));
  localparam logic signed [WEIGHT_W-1:0] W_MIN = WEIGHT_W'(weight_min(WEIGHT_W));

  always_comb begin
    result = weight;
    if (step_up) begin
      if (weight != W_MAX) result = weight + WEIGHT_W'(1);
    end else begin
      if (weight != W_MIN) result = weight - WEIGHT_W'(1);
    end
  end

endmodule

// File: rtl/perceptron_weight_table.sv
// Perceptron weight store: NUM_WAYS parallel registered lookups plus the
// threshold-gated read-modify-write training sequence.
//
// state    | meaning
// IDLE     | accepts train (priority) or lookup requests; evaluates threshold
// TRAIN_RD | latched entry is read into the update register
// TRAIN_WR | saturated vector written back, train_done pulses
module perceptron_weight_table
  import perceptron_pkg::*;
#(
  parameter  int NUM_WAYS = 4,
  parameter  int HIST_LEN = 8,
  parameter  int WEIGHT_W = 8,
  parameter  int DEPTH    = 256,
  parameter  int THETA    = 14,
  parameter  int SUM_W    = 12,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int ENTRY_W  = (HIST_LEN + 1) * WEIGHT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lookup_valid,
  output logic                        lookup_ready,
  input  logic [NUM_WAYS*IDX_W-1:0]   lookup_idx,
  output logic                        rd_valid,
  output logic [NUM_WAYS*ENTRY_W-1:0] rd_weights,
  input  logic                        train_valid,
  output logic                        train_ready,
  input  logic [IDX_W-1:0]            train_idx,
  input  logic [HIST_LEN-1:0]         train_ghr,
  input  logic                        train_taken,
  input  logic signed [SUM_W-1:0]     train_sum,
  output logic                        train_done,
  output logic                        train_updated
);

  logic [ENTRY_W-1:0]          mem [DEPTH];
  logic [DEPTH-1:0]            valid_q;
  train_state_e                state_q, state_d;
  logic [IDX_W-1:0]            tr_idx_q;
  logic [HIST_LEN-1:0]         tr_ghr_q;
  logic                        tr_taken_q;
  logic [ENTRY_W-1:0]          upd_q;
  logic [ENTRY_W-1:0]          new_entry;
  logic [NUM_WAYS*ENTRY_W-1:0] rd_next;
  logic                        lookup_acc;
  logic                        train_acc;
  logic                        need;

  assign lookup_acc = lookup_valid && lookup_ready;
  assign train_acc  = train_valid && train_ready;
  assign need       = train_needed(32'(train_sum), train_taken, THETA);

  // Invalid entries read as zero so reset never has to clear the array itself.
  for (genvar k = 0; k < NUM_WAYS; k++) begin : g_way
    logic [IDX_W-1:0] idx;
    assign idx = lookup_idx[k*IDX_W +: IDX_W];
    assign rd_next[k*ENTRY_W +: ENTRY_W] = valid_q[idx] ? mem[idx] : '0;
  end

  for (genvar j = 0; j <= HIST_LEN; j++) begin : g_sat
    logic step_up;
    if (j == 0) begin : g_bias
      assign step_up = tr_taken_q;
    end else begin : g_hist
      assign step_up = ~(tr_taken_q ^ tr_ghr_q[j-1]);
    end
    weight_sat_update #(.WEIGHT_W(WEIGHT_W)) u_sat (
      .weight  (upd_q[j*WEIGHT_W +: WEIGHT_W]),
      .step_up (step_up),
      .result  (new_entry[j*WEIGHT_W +: WEIGHT_W])
    );
  end

  always_comb begin
    state_d      = state_q;
    train_ready  = 1'b0;
    lookup_ready = 1'b0;
    case (state_q)
      IDLE: begin
        train_ready  = 1'b1;
        lookup_ready = !train_valid;
        if (train_valid && need) state_d = TRAIN_RD;
      end
      TRAIN_RD: state_d = TRAIN_WR;
      TRAIN_WR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      rd_valid      <= 1'b0;
      rd_weights    <= '0;
      train_done    <= 1'b0;
      train_updated <= 1'b0;
      tr_idx_q      <= '0;
      tr_ghr_q      <= '0;
      tr_taken_q    <= 1'b0;
      upd_q         <= '0;
    end else begin
      state_q       <= state_d;
      rd_valid      <= lookup_acc;
      train_done    <= (train_acc && !need) || (state_q == TRAIN_RD);
      train_updated <= (state_q == TRAIN_RD);
      if (lookup_acc) rd_weights <= rd_next;
      if (train_acc) begin
        tr_idx_q   <= train_idx;
        tr_ghr_q   <= train_ghr;
        tr_taken_q <= train_taken;
      end
      if (state_q == TRAIN_RD) upd_q <= valid_q[tr_idx_q] ? mem[tr_idx_q] : '0;
      if (state_q == TRAIN_WR) valid_q[tr_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state_q == TRAIN_WR) mem[tr_idx_q] <= new_entry;
  end

endmodule

// File: tb/tb_perceptron_weight_table.sv
// Directed bench for perceptron_weight_table: an arithmetic model of the table
// is compared against the DUT every cycle, plus literal weight/timing pins.
module tb_perceptron_weight_table;

  localparam int NW = 4, HL = 8, WW = 8, DEPTH = 256, IW = 8, SW = 12, THETA = 14;
  localparam int EW = (HL + 1) * WW;
  localparam int BW = NW * EW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            lookup_valid = 1'b0;
  logic            lookup_ready;
  logic [NW*IW-1:0] lookup_idx = '0;
  logic            rd_valid;
  logic [BW-1:0]   rd_weights;
  logic            train_valid = 1'b0;
  logic            train_ready;
  logic [IW-1:0]   train_idx = '0;
  logic [HL-1:0]   train_ghr = '0;
  logic            train_taken = 1'b0;
  logic signed [SW-1:0] train_sum = '0;
  logic            train_done;
  logic            train_updated;

  perceptron_weight_table dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_idx(lookup_idx),
    .rd_valid(rd_valid), .rd_weights(rd_weights),
    .train_valid(train_valid), .train_ready(train_ready), .train_idx(train_idx),
    .train_ghr(train_ghr), .train_taken(train_taken), .train_sum(train_sum),
    .train_done(train_done), .train_updated(train_updated)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model state
  int          mw [DEPTH][HL+1];
  bit          mvalid [DEPTH];
  int          busy = 0;
  int          p_idx;
  logic [HL-1:0] p_ghr;
  bit          p_taken;
  logic        exp_rd_valid = 1'b0, exp_done = 1'b0, exp_upd = 1'b0;
  logic [BW-1:0] exp_rd_w = '0;
  int          m_sum, m_step, m_v, m_ix;
  int          m_new [HL+1];

  function automatic int mread(int idx, int j);
    return mvalid[idx] ? mw[idx][j] : 0;
  endfunction

  function automatic bit model_need(int s, bit taken);
    bit st;
    int mag;
    st  = (s >= 0);
    mag = (s < 0) ? -s : s;
    return (st != taken) || (mag <= THETA);
  endfunction

  task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pin(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_rd_valid", BW'(rd_valid), '0);
      check("reset_rd_weights", rd_weights, '0);
      check("reset_train_done", BW'(train_done), '0);
      check("reset_train_updated", BW'(train_updated), '0);
      check("reset_train_ready", BW'(train_ready), BW'(1));
      busy = 0;
      for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
      exp_rd_valid = 1'b0; exp_done = 1'b0; exp_upd = 1'b0; exp_rd_w = '0;
    end else begin
      check("rd_valid", BW'(rd_valid), BW'(exp_rd_valid));
      check("rd_weights", rd_weights, exp_rd_w);
      check("train_done", BW'(train_done), BW'(exp_done));
      check("train_updated", BW'(train_updated), BW'(exp_upd));
      check("train_ready", BW'(train_ready), BW'(busy == 0));
      check("lookup_ready", BW'(lookup_ready), BW'(busy == 0 && !train_valid));
      exp_rd_valid = 1'b0; exp_done = 1'b0; exp_upd = 1'b0;
      if (busy == 0 && lookup_valid && !train_valid) begin
        exp_rd_valid = 1'b1;
        for (int k = 0; k < NW; k++) begin
          m_ix = int'(lookup_idx[k*IW +: IW]);
          for (int j = 0; j <= HL; j++)
            exp_rd_w[(k*(HL+1)+j)*WW +: WW] = WW'(mread(m_ix, j));
        end
      end
      if (busy == 2) begin
        exp_done = 1'b1; exp_upd = 1'b1;
      end
      if (busy == 1) begin
        for (int j = 0; j <= HL; j++) begin
          if (j == 0) m_step = p_taken ? 1 : -1;
          else        m_step = (p_taken == p_ghr[j-1]) ? 1 : -1;
          m_v = mread(p_idx, j) + m_step;
          if (m_v > 127)  m_v = 127;
          if (m_v < -128) m_v = -128;
          m_new[j] = m_v;
        end
        for (int j = 0; j <= HL; j++) mw[p_idx][j] = m_new[j];
        mvalid[p_idx] = 1'b1;
      end
      if (busy > 0) begin
        busy--;
      end else if (train_valid) begin
        m_sum = $signed(train_sum);
        if (model_need(m_sum, train_taken)) begin
          busy = 2; p_idx = int'(train_idx); p_ghr = train_ghr; p_taken = train_taken;
        end else begin
          exp_done = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int wt(int way, int j);
    return int'($signed(rd_weights[(way*(HL+1)+j)*WW +: WW]));
  endfunction

  task automatic do_lookup(input logic [7:0] a, b, c, d);
    int n;
    lookup_valid = 1'b1;
    lookup_idx   = {d, c, b, a};
    #1;
    n = 0;
    while (!lookup_ready && n < 20) begin cyc(); n++; end
    if (!lookup_ready) pin("lookup_wait_timeout", n, 0);
    cyc();
    lookup_valid = 1'b0;
  endtask

  task automatic do_train(input logic [7:0] idx, input logic [7:0] ghr, input bit taken,
                          input int sum, output int lat);
    int n;
    train_valid = 1'b1; train_idx = idx; train_ghr = ghr;
    train_taken = taken; train_sum = SW'(sum);
    #1;
    n = 0;
    while (!train_ready && n < 20) begin cyc(); n++; end
    if (!train_ready) pin("train_wait_timeout", n, 0);
    cyc();
    train_valid = 1'b0;
    lat = 1;
    while (!train_done && lat < 10) begin cyc(); lat++; end
  endtask

  initial begin
    int lat;
    int n;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    pin("post_reset_lookup_ready", int'(lookup_ready), 1);
    pin("post_reset_train_ready", int'(train_ready), 1);

    do_lookup(8'd0, 8'd5, 8'd5, 8'd255);
    pin("first_lookup_rd_valid", int'(rd_valid), 1);
    check("first_lookup_zero", rd_weights, '0);

    do_train(8'd3, 8'b0000_0001, 1'b1, 0, lat);
    pin("train3_latency", lat, 2);
    pin("train3_updated", int'(train_updated), 1);
    do_lookup(8'd3, 8'd3, 8'd3, 8'd3);
    pin("idx3_w0", wt(0, 0), 1);
    pin("idx3_w1", wt(0, 1), 1);
    pin("idx3_w2", wt(0, 2), -1);
    pin("idx3_w8", wt(0, 8), -1);
    pin("idx3_way3_w1", wt(3, 1), 1);

    do_train(8'd3, 8'h00, 1'b1, 40, lat);
    pin("confident_latency", lat, 1);
    pin("confident_updated", int'(train_updated), 0);
    do_lookup(8'd3, 8'd0, 8'd0, 8'd0);
    pin("idx3_unchanged_w0", wt(0, 0), 1);

    do_train(8'd4, 8'hAA, 1'b1, 14, lat);
    pin("theta_edge_latency", lat, 2);
    do_train(8'd4, 8'hAA, 1'b1, 15, lat);
    pin("above_theta_latency", lat, 1);
    do_train(8'd4, 8'h0F, 1'b1, -15, lat);
    pin("sign_mismatch_latency", lat, 2);
    do_train(8'd4, 8'h00, 1'b0, -2048, lat);
    pin("most_negative_latency", lat, 1);
    do_train(8'd4, 8'h00, 1'b0, 0, lat);
    pin("zero_sum_not_taken_latency", lat, 2);
    do_lookup(8'd4, 8'd3, 8'd4, 8'd0);
    pin("idx4_w0", wt(0, 0), 1);
    pin("idx4_w1", wt(0, 1), 1);
    pin("idx4_w2", wt(0, 2), 3);

    for (int i = 0; i < 130; i++) do_train(8'd7, 8'hFF, 1'b1, 0, lat);
    for (int i = 0; i < 130; i++) do_train(8'd8, 8'hFF, 1'b0, 0, lat);
    do_lookup(8'd7, 8'd8, 8'd7, 8'd8);
    for (int j = 0; j <= HL; j++) begin
      pin("sat_pos", wt(0, j), 127);
      pin("sat_neg", wt(1, j), -128);
    end

    train_valid = 1'b1; train_idx = 8'd3; train_ghr = 8'h00; train_taken = 1'b1; train_sum = '0;
    lookup_valid = 1'b1; lookup_idx = {4{8'd3}};
    #1;
    pin("priority_lookup_ready", int'(lookup_ready), 0);
    cyc();
    train_valid = 1'b0;
    n = 0;
    while (!lookup_ready && n < 20) begin cyc(); n++; end
    pin("priority_lookup_wait", n, 2);
    cyc();
    lookup_valid = 1'b0;
    pin("priority_w0", wt(0, 0), 2);
    pin("priority_w1", wt(0, 1), 0);

    train_valid = 1'b1; train_idx = 8'd9; train_ghr = 8'h5A; train_taken = 1'b1; train_sum = '0;
    cyc();
    train_valid = 1'b0;
    rst = 1'b0;
    #1;
    pin("abort_done_in_reset", int'(train_done), 0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    pin("abort_done_after", int'(train_done), 0);
    do_lookup(8'd9, 8'd9, 8'd3, 8'd7);
    check("abort_entry_zero", rd_weights, '0);

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
